sd_cmd_sequencer: RTL and testbench
===================================

# sd_cmd_sequencer

Sequences one SD-card SPI-mode command transaction. It accepts a command index and argument from the SD reader, builds the 48-bit frame (start bits, index, argument, CRC7, end bit), and drives the 48-bit command serializer through its en/done handshake. It then samples MISO until an R1 byte arrives or the NCR limit expires, and returns the result. It sits between the SD reader FSM and the serializer, and owns chip select for the transaction.

## Interface
- `NCR_MAX`, 8: maximum response bytes polled before timeout (1..255).
- `DATA_BITS`, 48: frame width; fixed to 48, present for parity with the serializer.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-low reset.
- `sclk_posedge` input 1: one-cycle strobe, SCLK rising edge (MISO sample point).
- `sclk_negedge` input 1: one-cycle strobe, SCLK falling edge (unused except for alignment checks).
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: high only in IDLE.
- `cmd_index` input 6: SD command number.
- `cmd_arg` input 32: command argument.
- `sender_en` output 1: one-cycle start pulse to the serializer.
- `sender_data` output 48: frame to the serializer, stable from the `sender_en` cycle until `sender_done`.
- `sender_done` input 1: serializer idle and not enabled.
- `miso` input 1: card data out.
- `cs_n` output 1: card chip select, active low.
- `resp_valid` output 1: one-cycle pulse when the transaction ends.
- `resp_r1` output 8: received R1 byte (0xFF on timeout).
- `resp_timeout` output 1: qualifies `resp_valid`; no R1 was received within `NCR_MAX` bytes.

## Operation
- States are IDLE, LOAD, SEND, WAIT_SEND, RESP and DONE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`, latch `cmd_index` and `cmd_arg`, drive `cs_n`=0, go to LOAD.
- **LOAD**
  - Build the frame: {2'b01, index, arg, crc7, 1'b1}.
  - With the CRC feature, run the serial CRC7 over the 40 header bits, one bit per clk (40 cycles), then go to SEND.
- **SEND**
  - Assert `sender_en` for exactly one cycle, then go to WAIT_SEND.
- **WAIT_SEND**
  - Wait for `sender_done`=1. `sender_done` is low during the `sender_en` cycle and does not return high until the frame has been shifted out.
  - Clear the bit counter, shift register and byte counter, then go to RESP.
- **RESP**
  - On each `sclk_posedge`, shift `miso` into an 8-bit register, MSB first.
  - After each 8th bit:
    - If bit 7 is 0: capture `resp_r1`, `resp_timeout`=0, go to DONE.
    - Else increment the byte count. When it reaches `NCR_MAX`: `resp_r1`=0xFF, `resp_timeout`=1, go to DONE.
- **DONE**
  - Pulse `resp_valid` for one cycle, drive `cs_n`=1, return to IDLE.
- Boundary behaviour:
  - `cmd_valid` outside IDLE is ignored; no queueing.
  - `cmd_index` is 6 bits, so bit 6 of the first byte is always 1.
  - `NCR_MAX`=1 means a single byte is polled.
  - Reset mid-transaction returns to IDLE immediately. The serializer is reset by the same system reset.

## Timing
- Reset values:
  - State IDLE.
  - `cmd_ready`=1, `sender_en`=0, `sender_data`=0, `cs_n`=1, `resp_valid`=0, `resp_r1`=0xFF, `resp_timeout`=0.
- `cmd_ready` falls the cycle after `cmd_valid` is sampled. `cs_n` falls in the same cycle.
- `sender_en` asserts:
  - 1 cycle after entering LOAD when the CRC feature is compiled out.
  - 41 cycles after entering LOAD when it is compiled in.
- Response bits are sampled only on `sclk_posedge` strobes seen in RESP. Strobes in WAIT_SEND are not sampled.
- `resp_valid` fires exactly 1 cycle after the decisive sample. `resp_r1` and `resp_timeout` hold their value until the next `resp_valid`.
- `cs_n` rises in the DONE cycle. `cmd_ready` returns high the cycle after.

## Configuration
- `SD_CMD_SEQ_CRC_EN` defined: the CRC7 is computed for every command.
- Undefined: no CRC logic, and LOAD takes 1 cycle. The CRC7 field is constant:
  - 7'h4A for index 0.
  - 7'h43 for index 8.
  - 7'h7F otherwise.
  - SPI mode ignores the CRC after CMD8.

## Structure
- Shared package `sd_pkg` holds:
  - The state enum.
  - The frame width 48.
  - Command constants CMD0, CMD8, CMD17, CMD55 and ACMD41.
  - `R1_IDLE`=8'h01.
- Sub-module `sd_crc7`: serial CRC7 with polynomial x^7+x^3+1, ports `clk`, `reset`, `clear`, `en`, `bit_in` and `crc[6:0]`. It is instantiated only under `SD_CMD_SEQ_CRC_EN`.

## Test plan
- CMD0, arg 0 (CRC on); card returns 0xFF then 0x01 → `sender_data`=48'h40_0000_0000_95, `resp_r1`=0x01, `resp_timeout`=0, `cs_n` low throughout the transaction.
- CMD8, arg 0x000001AA → `sender_data`=48'h48_0000_01AA_87.
- CMD17 arg 0 → CRC byte 0x55; CMD55 arg 0 → CRC byte 0x65.
- MISO held high, `NCR_MAX`=8 → after 64 `sclk_posedge` strobes in RESP: `resp_valid` with `resp_r1`=0xFF, `resp_timeout`=1.
- `reset` asserted low during RESP → asynchronous return to IDLE, `cs_n`=1, no `resp_valid`; a following CMD0 completes normally.
- `cmd_valid` pulsed during WAIT_SEND → ignored; exactly one `resp_valid` per accepted command. CRC off → CMD17 frame ends 0xFF.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD-card SPI command path.
// Holds the sequencer state enum, frame width, command numbers and the fixed CRC7 table.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_SEND,
        ST_RESP,
        ST_DONE
    } sd_state_t;

    localparam int FRAME_W = 48;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;

    localparam logic [7:0] R1_IDLE = 8'h01;

    // The card only checks CRC on CMD0 and CMD8 in SPI mode; everything else gets all-ones.
    function automatic logic [6:0] crc7_const(input logic [5:0] idx);
        case (idx)
            CMD0:    crc7_const = 7'h4A;
            CMD8:    crc7_const = 7'h43;
            default: crc7_const = 7'h7F;
        endcase
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one message bit per enabled clock, MSB first.
module sd_crc7 (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic fb;

    assign fb = bit_in ^ crc[6];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
        end
    end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// One SD SPI-mode command transaction: frame build, serializer handshake, R1 poll.
// Define SD_CMD_SEQ_CRC_EN to compute CRC7 in hardware; otherwise a fixed CRC table is used.
//
// state      | meaning
// IDLE       | ready for a command, cs_n high
// LOAD       | build frame (40 extra cycles when CRC is computed)
// SEND       | one-cycle serializer start pulse
// WAIT_SEND  | wait for serializer to finish shifting the frame
// RESP       | shift MISO on SCLK rising edges until R1 or NCR limit
// DONE       | pulse resp_valid, release cs_n
module sd_cmd_sequencer
    import sd_pkg::*;
#(
    parameter int NCR_MAX   = 8,
    parameter int DATA_BITS = 48
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sclk_posedge,
    input  logic                 sclk_negedge,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [5:0]           cmd_index,
    input  logic [31:0]          cmd_arg,
    output logic                 sender_en,
    output logic [DATA_BITS-1:0] sender_data,
    input  logic                 sender_done,
    input  logic                 miso,
    output logic                 cs_n,
    output logic                 resp_valid,
    output logic [7:0]           resp_r1,
    output logic                 resp_timeout
);

    localparam logic [7:0] NCR_LIM = 8'(NCR_MAX);

    sd_state_t   state;
    logic [5:0]  idx_q;
    logic [31:0] arg_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt;
    logic [7:0]  byte_cnt;
    logic [39:0] header;
    logic [6:0]  crc_field;
    logic        load_done;
    logic        sample;
    logic [7:0]  shift_nx;

    assign header   = {2'b01, idx_q, arg_q};
    // A strobe pair landing on the same cycle means SCLK is misaligned; don't sample it.
    assign sample   = sclk_posedge & ~sclk_negedge;
    assign shift_nx = {shift_q[6:0], miso};

`ifdef SD_CMD_SEQ_CRC_EN
    logic [5:0]  crc_cnt;
    logic [39:0] crc_sr;
    logic        crc_en;
    logic [6:0]  crc;

    assign crc_en    = (state == ST_LOAD) && (crc_cnt != 6'd40);
    assign load_done = (crc_cnt == 6'd40);
    assign crc_field = crc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_cnt <= '0;
            crc_sr  <= '0;
        end else if (state == ST_IDLE) begin
            crc_cnt <= '0;
            crc_sr  <= {2'b01, cmd_index, cmd_arg};
        end else if (crc_en) begin
            crc_cnt <= crc_cnt + 6'd1;
            crc_sr  <= {crc_sr[38:0], 1'b0};
        end
    end

    sd_crc7 u_crc7 (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ST_IDLE),
        .en     (crc_en),
        .bit_in (crc_sr[39]),
        .crc    (crc)
    );
`else
    assign load_done = 1'b1;
    assign crc_field = crc7_const(idx_q);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            idx_q        <= '0;
            arg_q        <= '0;
            shift_q      <= '0;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            cmd_ready    <= 1'b1;
            sender_en    <= 1'b0;
            sender_data  <= '0;
            cs_n         <= 1'b1;
            resp_valid   <= 1'b0;
            resp_r1      <= 8'hFF;
            resp_timeout <= 1'b0;
        end else begin
            sender_en  <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        idx_q     <= cmd_index;
                        arg_q     <= cmd_arg;
                        cs_n      <= 1'b0;
                        cmd_ready <= 1'b0;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (load_done) begin
                        sender_data <= {header, crc_field, 1'b1};
                        sender_en   <= 1'b1;
                        state       <= ST_SEND;
                    end
                end
                ST_SEND: state <= ST_WAIT_SEND;
                ST_WAIT_SEND: begin
                    if (sender_done) begin
                        bit_cnt  <= '0;
                        shift_q  <= '0;
                        byte_cnt <= '0;
                        state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (sample) begin
                        shift_q <= shift_nx;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (!shift_nx[7]) begin
                                resp_r1      <= shift_nx;
                                resp_timeout <= 1'b0;
                                resp_valid   <= 1'b1;
                                cs_n         <= 1'b1;
                                state        <= ST_DONE;
                            end else if (byte_cnt + 8'd1 == NCR_LIM) begin
                                resp_r1      <= 8'hFF;
                                resp_timeout <= 1'b1;
                                resp_valid   <= 1'b1;
                                cs_n         <= 1'b1;
                                state        <= ST_DONE;
                            end else begin
                                byte_cnt <= byte_cnt + 8'd1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench for sd_cmd_sequencer: frames, R1 capture, NCR timeout, reset, ignored requests.
module tb_sd_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sclk_posedge = 1'b0;
    logic        sclk_negedge = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic        sender_en;
    logic [47:0] sender_data;
    logic        sender_done = 1'b1;
    logic        miso = 1'b1;
    logic        cs_n;
    logic        resp_valid;
    logic [7:0]  resp_r1;
    logic        resp_timeout;

    int errors = 0;
    int checks = 0;
    int rv_count = 0;
    logic [7:0] last_r1 = '0;
    logic       last_to = 1'b0;

`ifdef SD_CMD_SEQ_CRC_EN
    localparam logic [7:0] CRC17 = 8'h55;
    localparam logic [7:0] CRC55 = 8'h65;
`else
    localparam logic [7:0] CRC17 = 8'hFF;
    localparam logic [7:0] CRC55 = 8'hFF;
`endif

    sd_cmd_sequencer #(.NCR_MAX(8), .DATA_BITS(48)) dut (
        .clk          (clk),
        .reset        (reset),
        .sclk_posedge (sclk_posedge),
        .sclk_negedge (sclk_negedge),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_index    (cmd_index),
        .cmd_arg      (cmd_arg),
        .sender_en    (sender_en),
        .sender_data  (sender_data),
        .sender_done  (sender_done),
        .miso         (miso),
        .cs_n         (cs_n),
        .resp_valid   (resp_valid),
        .resp_r1      (resp_r1),
        .resp_timeout (resp_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            rv_count = rv_count + 1;
            last_r1  = resp_r1;
            last_to  = resp_timeout;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg);
        @(negedge clk);
        cmd_index = idx;
        cmd_arg   = arg;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_frame(output logic [47:0] f, output bit seen);
        seen = 1'b0;
        f    = '0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (sender_en === 1'b1) begin
                seen        = 1'b1;
                f           = sender_data;
                sender_done = 1'b0;
            end
        end
    endtask

    task automatic release_sender();
        tick(5);
        sender_done = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            miso = b[i];
            @(negedge clk);
            sclk_posedge = 1'b1;
            @(negedge clk);
            sclk_posedge = 1'b0;
            sclk_negedge = 1'b1;
            @(negedge clk);
            sclk_negedge = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        checks++; if (sender_en !== 1'b0) begin errors++; $display("FAIL reset_sender_en got=%b exp=0", sender_en); end
        checks++; if (sender_data !== 48'h0) begin errors++; $display("FAIL reset_sender_data got=%h exp=0", sender_data); end
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got=%b exp=1", cs_n); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_r1 !== 8'hFF) begin errors++; $display("FAIL reset_resp_r1 got=%h exp=ff", resp_r1); end
        checks++; if (resp_timeout !== 1'b0) begin errors++; $display("FAIL reset_resp_timeout got=%b exp=0", resp_timeout); end
        reset = 1'b1;
        tick(2);
    endtask

    task automatic test_cmd0();
        logic [47:0] f;
        bit seen;
        int rv0;
        rv0 = rv_count;
        issue(6'd0, 32'h0);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL cmd0_ready_fall got=%b exp=0", cmd_ready); end
        checks++; if (cs_n !== 1'b0) begin errors++; $display("FAIL cmd0_cs_fall got=%b exp=0", cs_n); end
        get_frame(f, seen);
        checks++; if (!seen) begin errors++; $display("FAIL cmd0_sender_en_seen got=0 exp=1"); end
        checks++; if (f !== 48'h40_0000_0000_95) begin errors++; $display("FAIL cmd0_frame got=%h exp=400000000095", f); end
        @(negedge clk);
        checks++; if (sender_en !== 1'b0) begin errors++; $display("FAIL cmd0_en_one_cycle got=%b exp=0", sender_en); end
        release_sender();
        send_bits(8'hFF, 8);
        checks++; if (rv_count !== rv0) begin errors++; $display("FAIL cmd0_no_early_resp got=%0d exp=%0d", rv_count, rv0); end
        checks++; if (cs_n !== 1'b0) begin errors++; $display("FAIL cmd0_cs_held got=%b exp=0", cs_n); end
        send_bits(8'h01, 8);
        checks++; if (rv_count !== rv0 + 1) begin errors++; $display("FAIL cmd0_resp_count got=%0d exp=%0d", rv_count, rv0 + 1); end
        checks++; if (last_r1 !== 8'h01) begin errors++; $display("FAIL cmd0_r1 got=%h exp=01", last_r1); end
        checks++; if (last_to !== 1'b0) begin errors++; $display("FAIL cmd0_timeout got=%b exp=0", last_to); end
        tick(2);
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL cmd0_cs_rise got=%b exp=1", cs_n); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd0_ready_rise got=%b exp=1", cmd_ready); end
        checks++; if (resp_r1 !== 8'h01) begin errors++; $display("FAIL cmd0_r1_hold got=%h exp=01", resp_r1); end
    endtask

    task automatic test_frames();
        logic [5:0]  idx_t [3] = '{6'd8, 6'd17, 6'd55};
        logic [31:0] arg_t [3] = '{32'h0000_01AA, 32'h0, 32'h0};
        logic [47:0] exp_t [3] = '{48'h48_0000_01AA_87, {40'h51_0000_0000, CRC17}, {40'h77_0000_0000, CRC55}};
        logic [7:0]  r1_t  [3] = '{8'h01, 8'h00, 8'h05};
        logic [47:0] f;
        bit seen;
        int rv0;
        for (int k = 0; k < 3; k++) begin
            rv0 = rv_count;
            issue(idx_t[k], arg_t[k]);
            get_frame(f, seen);
            checks++; if (!seen || f !== exp_t[k]) begin errors++; $display("FAIL frame_cmd%0d got=%h exp=%h", idx_t[k], f, exp_t[k]); end
            release_sender();
            send_bits(r1_t[k], 8);
            checks++; if (rv_count !== rv0 + 1 || last_r1 !== r1_t[k]) begin errors++; $display("FAIL r1_cmd%0d got=%h count=%0d exp=%h", idx_t[k], last_r1, rv_count - rv0, r1_t[k]); end
            tick(3);
        end
    endtask

    task automatic test_timeout();
        logic [47:0] f;
        bit seen;
        int rv0;
        rv0 = rv_count;
        issue(6'd0, 32'h0);
        get_frame(f, seen);
        release_sender();
        for (int b = 0; b < 7; b++) send_bits(8'hFF, 8);
        checks++; if (rv_count !== rv0) begin errors++; $display("FAIL timeout_not_before_ncr got=%0d exp=%0d", rv_count, rv0); end
        send_bits(8'hFF, 8);
        checks++; if (rv_count !== rv0 + 1) begin errors++; $display("FAIL timeout_resp_count got=%0d exp=%0d", rv_count, rv0 + 1); end
        checks++; if (last_r1 !== 8'hFF) begin errors++; $display("FAIL timeout_r1 got=%h exp=ff", last_r1); end
        checks++; if (last_to !== 1'b1) begin errors++; $display("FAIL timeout_flag got=%b exp=1", last_to); end
        tick(2);
        checks++; if (resp_timeout !== 1'b1) begin errors++; $display("FAIL timeout_hold got=%b exp=1", resp_timeout); end
    endtask

    task automatic test_reset_mid();
        logic [47:0] f;
        bit seen;
        int rv0;
        rv0 = rv_count;
        issue(6'd0, 32'h0);
        get_frame(f, seen);
        release_sender();
        send_bits(8'hF0, 4);
        reset = 1'b0;
        sender_done = 1'b1;
        #1;
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL rstmid_cs_n got=%b exp=1", cs_n); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", cmd_ready); end
        @(negedge clk);
        reset = 1'b1;
        tick(3);
        checks++; if (rv_count !== rv0) begin errors++; $display("FAIL rstmid_no_resp got=%0d exp=%0d", rv_count, rv0); end
        issue(6'd0, 32'h0);
        get_frame(f, seen);
        checks++; if (!seen || f !== 48'h40_0000_0000_95) begin errors++; $display("FAIL rstmid_cmd0_frame got=%h exp=400000000095", f); end
        release_sender();
        send_bits(8'h01, 8);
        checks++; if (rv_count !== rv0 + 1 || last_r1 !== 8'h01) begin errors++; $display("FAIL rstmid_cmd0_r1 got=%h count=%0d exp=01", last_r1, rv_count - rv0); end
        tick(3);
    endtask

    task automatic test_ignore_wait_send();
        logic [47:0] f;
        bit seen;
        int rv0;
        rv0 = rv_count;
        issue(6'd17, 32'h0);
        get_frame(f, seen);
        checks++; if (!seen || f !== {40'h51_0000_0000, CRC17}) begin errors++; $display("FAIL ignore_cmd17_frame got=%h exp=%h", f, {40'h51_0000_0000, CRC17}); end
        @(negedge clk);
        cmd_index = 6'd55;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        send_bits(8'h00, 8);
        checks++; if (rv_count !== rv0) begin errors++; $display("FAIL ignore_wait_send_strobes got=%0d exp=%0d", rv_count, rv0); end
        release_sender();
        send_bits(8'h05, 8);
        checks++; if (last_r1 !== 8'h05) begin errors++; $display("FAIL ignore_r1 got=%h exp=05", last_r1); end
        tick(20);
        checks++; if (rv_count !== rv0 + 1) begin errors++; $display("FAIL ignore_one_resp got=%0d exp=%0d", rv_count, rv0 + 1); end
        checks++; if (cmd_ready !== 1'b1 || cs_n !== 1'b1) begin errors++; $display("FAIL ignore_idle got=ready%b cs%b exp=ready1 cs1", cmd_ready, cs_n); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cmd0();
        test_frames();
        test_timeout();
        test_reset_mid();
        test_ignore_wait_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
